// File: rtl/core_pkg.sv
// Shared core definitions: data width, instruction size and the
// prefetch entry layout carried from fetch to decode.
package core_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;

  // One prefetched word together with the address it was fetched from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage : core_pkg

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO. It has push, pop and flush inputs and an
// occupancy count output. The head entry reads as zero while the FIFO is empty.
module fetch_fifo
  import core_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_flush,
  input  fetch_entry_t  i_wdata,
  output fetch_entry_t  o_head,
  output logic [CW-1:0] o_count
);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  // Storage array: written on push, no reset needed since count gates the head.
  always_ff @(posedge i_clk) begin
    if (i_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointer and occupancy tracking; flush empties the FIFO and rewinds pointers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Head entry, forced to zero when nothing is held.
  always_comb begin
    o_head = '0;
    if (r_count != '0) o_head = r_mem[r_rd_ptr];
  end

  assign o_count = r_count;

endmodule : fetch_fifo

// File: rtl/fetch_unit.sv
// Instruction fetch unit. It holds the PC and presents it to a combinational ROM.
// It prefetches words into fetch_fifo and serves decode over valid/ready.
// A redirect loads a new PC and flushes every prefetched word.
module fetch_unit
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned     FIFO_DEPTH = 2
) (
  input  logic            clock,
  input  logic            reset_n,
  output logic [XLEN-1:0] rom_address,
  input  logic [XLEN-1:0] rom_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr_data,
  output logic [XLEN-1:0] instr_pc
);

  localparam int unsigned     CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]   DEPTH_CNT = CW'(FIFO_DEPTH);
  localparam logic [XLEN-1:0] ALIGN     = ~XLEN'(INSTR_BYTES - 1);

  logic [XLEN-1:0] r_pc;
  logic [CW-1:0]   w_count;
  logic            w_pop;
  logic            w_push;
  logic [XLEN-1:0] w_redirect_pc;
  fetch_entry_t    w_wdata;
  fetch_entry_t    w_head;

  assign w_redirect_pc = redirect_pc & ALIGN;

  // Handshake decode. Pushing into a full FIFO is allowed when the head is
  // leaving in the same cycle. A redirect suppresses the push.
  always_comb begin
    w_pop   = instr_valid & instr_ready;
    w_push  = ~redirect_valid & ((w_count < DEPTH_CNT) | w_pop);
    w_wdata = '{pc: r_pc, instr: rom_data};
  end

  // Program counter: redirect wins, otherwise advance one word per push.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pc <= RESET_PC & ALIGN;
    end else if (redirect_valid) begin
      r_pc <= w_redirect_pc;
    end else if (w_push) begin
      r_pc <= r_pc + XLEN'(INSTR_BYTES);
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clock),
    .i_rst_n (reset_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .i_wdata (w_wdata),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign rom_address = r_pc;
  assign instr_valid = (w_count != '0);
  assign instr_data  = w_head.instr;
  assign instr_pc    = w_head.pc;

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit. It runs directed scenarios followed by a
// randomized phase. Expected values come from a queue-based model of the prefetch stream.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int unsigned DEPTH  = 2;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] rom_address;
  logic [31:0] rom_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;

  int unsigned total = 0;
  int unsigned bad   = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] mpc;

  fetch_unit #(
    .RESET_PC   (RST_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .rom_address    (rom_address),
    .rom_data       (rom_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc)
  );

  always #5 clock = ~clock;

  // ROM contents: fixed word at address 0, scrambled address elsewhere.
  function automatic logic [31:0] rom_fn(input logic [31:0] a);
    if (a == 32'h0) return 32'h00b0_0093;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  assign rom_data = rom_fn(rom_address);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model's view of the stream.
  task automatic check_model();
    logic [31:0] e_data;
    logic [31:0] e_pc;
    e_data = '0;
    e_pc   = '0;
    if (mq.size() != 0) begin
      e_data = mq[0].instr;
      e_pc   = mq[0].pc;
    end
    chk("rom_address", rom_address, mpc);
    chk("instr_valid", {31'b0, instr_valid}, {31'b0, mq.size() != 0});
    chk("instr_data", instr_data, e_data);
    chk("instr_pc", instr_pc, e_pc);
  endtask

  // One clock cycle with the given inputs. The model advances at the edge and
  // the outputs are checked 1 time unit later.
  task automatic step(input logic rdy, input logic rv, input logic [31:0] rpc);
    bit pop;
    bit push;
    instr_ready    = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(posedge clock);
    if (reset_n) begin
      pop  = (mq.size() != 0) && rdy;
      push = !rv && ((mq.size() < DEPTH) || pop);
      if (rv) begin
        mq.delete();
        mpc = {rpc[31:2], 2'b00};
      end else begin
        if (pop) void'(mq.pop_front());
        if (push) begin
          mq.push_back('{pc: mpc, instr: rom_fn(mpc)});
          mpc = mpc + 32'd4;
        end
      end
    end
    #1;
    redirect_valid = 1'b0;
    check_model();
  endtask

  initial begin
    mpc = RST_PC & ~32'h3;

    // Reset state before any edge.
    #2;
    chk("rst_rom_address", rom_address, 32'h0);
    chk("rst_valid", {31'b0, instr_valid}, 32'h0);
    chk("rst_data", instr_data, 32'h0);
    chk("rst_pc", instr_pc, 32'h0);

    // Streaming with decode always ready.
    reset_n = 1'b1;
    step(1'b1, 1'b0, '0);
    chk("first_valid", {31'b0, instr_valid}, 32'h1);
    chk("first_data", instr_data, 32'h00b0_0093);
    chk("first_pc", instr_pc, 32'h0);
    step(1'b1, 1'b0, '0); chk("seq_pc4", instr_pc, 32'd4);
    step(1'b1, 1'b0, '0); chk("seq_pc8", instr_pc, 32'd8);
    step(1'b1, 1'b0, '0); chk("seq_pc12", instr_pc, 32'd12);

    // Backpressure from a fresh restart at address 0.
    step(1'b0, 1'b1, 32'h0);
    chk("restart_empty", {31'b0, instr_valid}, 32'h0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0);
    chk("stall_rom_address", rom_address, 32'd8);
    chk("stall_head_pc", instr_pc, 32'h0);
    chk("stall_head_data", instr_data, 32'h00b0_0093);
    step(1'b1, 1'b0, '0); chk("release_pc4", instr_pc, 32'd4);
    step(1'b1, 1'b0, '0); chk("release_pc8", instr_pc, 32'd8);

    // Refill the FIFO, then redirect while it is full.
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 32'h0000_0042);
    chk("redir_full_valid", {31'b0, instr_valid}, 32'h0);
    chk("redir_full_rom", rom_address, 32'h40);
    step(1'b1, 1'b0, '0);
    chk("redir_full_target", instr_pc, 32'h40);

    // Redirect in the same cycle that decode accepts a valid head.
    step(1'b1, 1'b1, 32'h0000_0100);
    chk("redir_pop_valid", {31'b0, instr_valid}, 32'h0);
    step(1'b1, 1'b0, '0); chk("redir_pop_t0", instr_pc, 32'h100);
    step(1'b1, 1'b0, '0); chk("redir_pop_t1", instr_pc, 32'h104);

    // PC wrap at the top of the address space.
    step(1'b1, 1'b1, 32'hFFFF_FFFF);
    step(1'b1, 1'b0, '0); chk("wrap_top", instr_pc, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, '0); chk("wrap_zero", instr_pc, 32'h0);
    step(1'b1, 1'b0, '0); chk("wrap_four", instr_pc, 32'h4);

    // Randomized traffic: ready toggling with occasional redirects.
    for (int i = 0; i < 300; i++) begin
      logic rdy;
      logic rv;
      rdy = ($urandom_range(3) != 0);
      rv  = ($urandom_range(15) == 0);
      step(rdy, rv, $urandom);
    end

    // Asynchronous reset between edges while the stream is running.
    step(1'b1, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    #2;
    reset_n = 1'b0;
    mq.delete();
    mpc = RST_PC & ~32'h3;
    #1;
    chk("async_valid", {31'b0, instr_valid}, 32'h0);
    chk("async_data", instr_data, 32'h0);
    chk("async_pc", instr_pc, 32'h0);
    chk("async_rom", rom_address, RST_PC);
    step(1'b1, 1'b0, '0);
    chk("held_reset_valid", {31'b0, instr_valid}, 32'h0);
    reset_n = 1'b1;
    step(1'b1, 1'b0, '0);
    chk("restart_pc", instr_pc, RST_PC);
    chk("restart_data", instr_data, 32'h00b0_0093);
    step(1'b1, 1'b0, '0);
    chk("restart_pc4", instr_pc, RST_PC + 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_fetch_unit

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch unit: the initiator that drives the word-addressed instruction ROM and hands fetched instructions to decode. Holds the program counter, presents it to the ROM each cycle, captures the combinational ROM word into a small prefetch FIFO, and serves decode over a valid/ready handshake. Supports a single-cycle PC redirect (branch/jump) that flushes all prefetched words.

## Interface
- RESET_PC, 32'h0000_0000: PC loaded on reset; low two bits ignored (forced to 0)
- FIFO_DEPTH, 2: prefetch entries; power of two, ≥2
- clock  input  1  single clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- rom_address  output  32  byte address to ROM; always word-aligned (= pc)
- rom_data  input  32  ROM word at rom_address, valid same cycle (combinational ROM)
- redirect_valid  input  1  load redirect_pc as next PC, flush FIFO
- redirect_pc  input  32  redirect target; bits [1:0] forced to 0
- instr_valid  output  1  FIFO head holds an instruction
- instr_ready  input  1  decode accepts head this cycle
- instr_data  output  32  instruction word at FIFO head
- instr_pc  output  32  address of instr_data

## Operation
- rom_address = pc, combinational from the PC register.
- pop = instr_valid & instr_ready; push = ~redirect_valid & (count < FIFO_DEPTH | pop).
- On push: enqueue {pc, rom_data}; pc <= pc + 4 (32-bit modulo; 32'hFFFF_FFFC wraps to 0).
- No push: pc holds.
- Redirect (highest priority): pc <= {redirect_pc[31:2], 2'b00}; count <= 0; no push, and any pop that cycle is still counted as accepted by decode but the FIFO is emptied regardless.
- Simultaneous push and pop on full FIFO: allowed, count unchanged.
- instr_valid = (count != 0); instr_data/instr_pc = head entry; both driven 0 when empty.
- Reset (asserted any time, including mid-stream): pc = RESET_PC & ~3, count = 0, read/write pointers = 0; outputs: rom_address = RESET_PC & ~3, instr_valid = 0, instr_data = 0, instr_pc = 0. Effect immediate (asynchronous), no clock needed.

## Timing
- Fetch-to-valid latency: 1 cycle (word presented in cycle N is at head with instr_valid in cycle N+1 if FIFO was empty).
- Steady-state throughput: 1 instruction/cycle with instr_ready held high.
- Redirect penalty: redirect in cycle N → instr_valid = 0 in N+1 → target instruction valid in N+2 with instr_pc = target.
- Backpressure: instr_valid, instr_data, instr_pc stable while instr_valid & ~instr_ready and no redirect.
- First push after reset deassertion occurs on first rising edge with reset_n high.

## Structure
- Shared package (core_pkg): XLEN = 32, INSTR_BYTES = 4, fetch entry typedef {pc[31:0], instr[31:0]}.
- One sub-module: fetch_fifo (synchronous FIFO, parameter DEPTH, push/pop/flush, count output, zero-on-empty head). PC register and push/redirect logic in fetch_unit.

## Test plan
- Reset with RESET_PC = 32'h0000_0000, ROM word 0 = 32'h00b0_0093, instr_ready = 1 → rom_address = 0 during reset; after one edge instr_valid = 1, instr_data = 32'h00b0_0093, instr_pc = 0; next cycles instr_pc = 4, 8, 12.
- Hold instr_ready = 0 for 5 cycles → FIFO fills to 2, rom_address stalls at 8, head stays {0, word0}; release → pcs 0, 4, 8 delivered on consecutive cycles, no gaps or duplicates.
- Redirect to 32'h0000_0042 while FIFO full → next cycle instr_valid = 0, rom_address = 32'h40; following cycle instr_pc = 32'h40.
- Redirect with instr_ready = 1 and valid head in same cycle → FIFO empty next cycle, no stale pc delivered afterwards.
- Redirect to 32'hFFFF_FFFC, instr_ready = 1 → instr_pc sequence 32'hFFFF_FFFC, 0, 4.
- Assert reset_n = 0 mid-stream between edges → instr_valid and instr_data drop to 0 immediately; rom_address = RESET_PC; fetch restarts from RESET_PC after release.
